// File: rtl/sub_bytes_seq.sv
// -----------------------------------------------------------------------------
// sub_bytes_seq
//   Handshaked AES SubBytes / InvSubBytes engine. A 128-bit state is accepted
//   on in_valid while idle. It is then substituted LANES bytes per cycle over
//   N = 16/LANES cycles, in ascending byte order. The result is held on
//   data_out with out_valid until out_ready. Fewer lanes means less S-box
//   logic but a longer latency.
//
//   S-boxes are computed arithmetically: the GF(2^8) inverse under the AES
//   polynomial x^8+x^4+x^3+x+1, followed by the AES affine transform. The
//   inverse box uses the inverse affine transform followed by the GF inverse.
//
// Parameters
//   LANES   S-box lanes (bytes per cycle): 1, 2, 4, 8 or 16
//   INV_EN  1: mode selects forward/inverse per block; 0: forward only
//
// Ports
//   clk        in   1    rising-edge clock
//   reset_n    in   1    asynchronous active-low reset
//   in_valid   in   1    data_in/mode valid
//   in_ready   out  1    engine idle, can accept a block
//   mode       in   1    0 = SubBytes, 1 = InvSubBytes (sampled on accept)
//   data_in    in   128  state; byte 0 = data_in[127:120], byte 15 = [7:0]
//   out_valid  out  1    data_out holds a finished block
//   out_ready  in   1    downstream accepts data_out
//   data_out   out  128  substituted state, same byte order; 0 unless done
//   busy       out  1    high while a block is being processed or held
// -----------------------------------------------------------------------------
module sub_bytes_seq #(
    parameter int LANES  = 16,
    parameter bit INV_EN = 1'b1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         mode,
    input  logic [127:0] data_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] data_out,
    output logic         busy
);

    localparam int N  = 16 / LANES;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
        $error("sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
    end

    // ------------------------------------------------------------------
    // GF(2^8) arithmetic and S-box functions
    // ------------------------------------------------------------------
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        acc = 8'h00;
        x   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return acc;
    endfunction

    // x^254 equals x^-1 for x != 0, and yields 0 for x == 0 as AES requires.
    // 254 = 0b11111110, so the result is the product of x^2, x^4, ..., x^128.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = x;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] d;
        d = {x, x} << n;
        return d[15:8];
    endfunction

    function automatic logic [7:0] fwd_sbox(input logic [7:0] x);
        logic [7:0] b;
        b = gf_inv(x);
        return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        return gf_inv(rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05);
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [127:0]    r_work;
    logic            r_mode;

    logic [7:0]      w_lane_in  [LANES];
    logic [7:0]      w_lane_out [LANES];
    logic [127:0]    w_work_next;

    // Lane j works on byte r_cnt*LANES + j. Byte k sits at bits [127-8k -: 8].
    for (genvar j = 0; j < LANES; j++) begin : g_lane
        assign w_lane_in[j] = r_work[8*(15 - (int'(r_cnt)*LANES + j)) +: 8];
        if (INV_EN) begin : g_fwd_inv
            assign w_lane_out[j] = r_mode ? inv_sbox(w_lane_in[j]) : fwd_sbox(w_lane_in[j]);
        end else begin : g_fwd_only
            assign w_lane_out[j] = fwd_sbox(w_lane_in[j]);
        end
    end

    // NOTE: Give every combinational output a full default first, so no path
    // can leave it unassigned and infer a latch.
    always_comb begin
        w_work_next = r_work;
        for (int j = 0; j < LANES; j++) begin
            w_work_next[8*(15 - (int'(r_cnt)*LANES + j)) +: 8] = w_lane_out[j];
        end
    end

    // Every output is a register. in_ready therefore has no combinational
    // dependence on in_valid, and data_out only carries a finished block.
    // NOTE: Sequential state uses nonblocking assignments only. All flops
    // update together from the values held before the edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: The work and output data registers are reset as well.
            // That makes data_out read 0 immediately after reset.
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_work    <= '0;
            r_mode    <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            data_out  <= '0;
            busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_work   <= data_in;
                        r_mode   <= INV_EN ? mode : 1'b0;
                        r_cnt    <= '0;
                        r_state  <= S_BUSY;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                S_BUSY: begin
                    r_work <= w_work_next;
                    if (r_cnt == LAST_CNT) begin
                        r_cnt     <= '0;
                        r_state   <= S_DONE;
                        out_valid <= 1'b1;
                        data_out  <= w_work_next;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    // The block is returned here and nothing is accepted on
                    // this edge. in_ready rises only once the FSM is idle.
                    if (out_ready) begin
                        r_state   <= S_IDLE;
                        out_valid <= 1'b0;
                        data_out  <= '0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sub_bytes_seq.sv
// -----------------------------------------------------------------------------
// tb_sub_bytes_seq
//   Four engine instances share clk and reset_n:
//     u0: LANES=16 INV_EN=1   u1: LANES=1 INV_EN=1
//     u2: LANES=4  INV_EN=1   u3: LANES=2 INV_EN=0
//   The reference S-box tables are generated by the classic 3-generator walk
//   of GF(2^8). The inverse table is the permutation inverse of the forward
//   table. The known AES vectors are used as literal expectations.
// -----------------------------------------------------------------------------
module tb_sub_bytes_seq;

    localparam int NI = 4;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         in_valid  [NI];
    logic         in_ready  [NI];
    logic         mode      [NI];
    logic [127:0] data_in   [NI];
    logic         out_valid [NI];
    logic         out_ready [NI];
    logic [127:0] data_out  [NI];
    logic         busy      [NI];

    int lanes_of [NI] = '{16, 1, 4, 2};
    bit inv_of   [NI] = '{1'b1, 1'b1, 1'b1, 1'b0};

    int checks = 0;
    int errors = 0;

    logic [7:0] sbox  [256];
    logic [7:0] isbox [256];

    always #5 clk = ~clk;

    sub_bytes_seq #(.LANES(16), .INV_EN(1'b1)) u0 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .mode(mode[0]), .data_in(data_in[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .data_out(data_out[0]), .busy(busy[0]));
    sub_bytes_seq #(.LANES(1), .INV_EN(1'b1)) u1 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .mode(mode[1]), .data_in(data_in[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .data_out(data_out[1]), .busy(busy[1]));
    sub_bytes_seq #(.LANES(4), .INV_EN(1'b1)) u2 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .mode(mode[2]), .data_in(data_in[2]), .out_valid(out_valid[2]),
        .out_ready(out_ready[2]), .data_out(data_out[2]), .busy(busy[2]));
    sub_bytes_seq #(.LANES(2), .INV_EN(1'b0)) u3 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
        .mode(mode[3]), .data_in(data_in[3]), .out_valid(out_valid[3]),
        .out_ready(out_ready[3]), .data_out(data_out[3]), .busy(busy[3]));

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Walk p over all non-zero field elements by repeated multiplication by 3.
    // q tracks the inverse of p (multiplication by 1/3), and the affine
    // transform of q gives S(p).
    task automatic build_tables();
        logic [7:0] p;
        logic [7:0] q;
        logic [7:0] x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ (q << 1);
            q = q ^ (q << 2);
            q = q ^ (q << 4);
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sbox[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbox[0] = 8'h63;
        for (int i = 0; i < 256; i++) isbox[sbox[i]] = 8'(i);
    endtask

    function automatic logic [127:0] model(input logic [127:0] d, input logic inv);
        logic [127:0] r;
        logic [7:0]   b;
        r = '0;
        for (int k = 0; k < 16; k++) begin
            b = d[127 - 8*k -: 8];
            r[127 - 8*k -: 8] = inv ? isbox[b] : sbox[b];
        end
        return r;
    endfunction

    // Send one block to instance k. Check the latency, the idle outputs while
    // busy, and the result. Hold the result for `hold` cycles with noisy
    // inputs, then return it and check that the engine is idle again.
    task automatic run_block(input int k, input logic [127:0] d, input logic m,
                             input logic [127:0] exp, input int hold, input string tag);
        int n;
        int lat;
        bit ok;
        n = 16 / lanes_of[k];
        check({tag, " in_ready before accept"}, 128'(in_ready[k]), 128'(1));
        in_valid[k] = 1'b1;
        data_in[k]  = d;
        mode[k]     = m;
        @(posedge clk); #1;
        in_valid[k] = 1'b0;
        lat = 0;
        ok  = 1'b1;
        while (out_valid[k] !== 1'b1 && lat < 200) begin
            if (in_ready[k] !== 1'b0 || busy[k] !== 1'b1 || data_out[k] !== 128'h0) ok = 1'b0;
            in_valid[k] = 1'($urandom);
            data_in[k]  = {$urandom, $urandom, $urandom, $urandom};
            mode[k]     = 1'($urandom);
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " latency"}, 128'(lat), 128'(n));
        check({tag, " outputs while busy"}, 128'(ok), 128'(1));
        check({tag, " data_out"}, data_out[k], exp);
        ok = 1'b1;
        for (int c = 0; c < hold; c++) begin
            in_valid[k] = 1'($urandom);
            data_in[k]  = {$urandom, $urandom, $urandom, $urandom};
            mode[k]     = 1'($urandom);
            @(posedge clk); #1;
            if (out_valid[k] !== 1'b1 || in_ready[k] !== 1'b0 || busy[k] !== 1'b1 ||
                data_out[k] !== exp) ok = 1'b0;
        end
        if (hold > 0) check({tag, " held result stable"}, 128'(ok), 128'(1));
        // Drive in_valid during the output handshake. It must not be accepted.
        out_ready[k] = 1'b1;
        in_valid[k]  = 1'b1;
        @(posedge clk); #1;
        out_ready[k] = 1'b0;
        in_valid[k]  = 1'b0;
        check({tag, " idle after handshake"},
              {out_valid[k], in_ready[k], busy[k]}, {1'b0, 1'b1, 1'b0});
        check({tag, " data_out cleared"}, data_out[k], 128'h0);
    endtask

    initial begin
        logic [127:0] v1;
        logic [127:0] r1;
        logic [127:0] d;
        logic         m;
        int           k;

        v1 = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
        r1 = 128'hd42711aee0bf98f1b8b45de51e415230;
        build_tables();

        for (int i = 0; i < NI; i++) begin
            in_valid[i]  = 1'b0;
            mode[i]      = 1'b0;
            data_in[i]   = '0;
            out_ready[i] = 1'b0;
        end
        reset_n = 1'b0;
        #23;
        for (int i = 0; i < NI; i++) begin
            check($sformatf("reset ctl u%0d", i),
                  {out_valid[i], in_ready[i], busy[i]}, {1'b0, 1'b1, 1'b0});
            check($sformatf("reset data u%0d", i), data_out[i], 128'h0);
        end
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Known forward vector on the 16-lane and 1-lane engines.
        run_block(0, v1, 1'b0, r1, 0, "fwd16");
        run_block(1, v1, 1'b0, r1, 2, "fwd1");

        // Inverse direction and the all-00 / all-63 pair.
        run_block(2, r1, 1'b1, v1, 0, "inv4");
        run_block(0, 128'h0, 1'b0, {16{8'h63}}, 0, "zero fwd");
        run_block(1, {16{8'h63}}, 1'b1, 128'h0, 0, "63 inv");

        // Long backpressure, then back-to-back blocks.
        d = {$urandom, $urandom, $urandom, $urandom};
        m = 1'($urandom);
        run_block(2, d, m, model(d, m), 10, "hold4");
        d = {$urandom, $urandom, $urandom, $urandom};
        run_block(2, d, 1'b0, model(d, 1'b0), 0, "after hold");

        // Asynchronous reset in the middle of processing on the 2-lane engine.
        in_valid[3] = 1'b1;
        data_in[3]  = v1;
        @(posedge clk); #1;
        in_valid[3] = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("async reset ctl", {out_valid[3], in_ready[3], busy[3]}, {1'b0, 1'b1, 1'b0});
        check("async reset data", data_out[3], 128'h0);
        #2;
        reset_n = 1'b1;
        @(posedge clk); #1;
        run_block(3, {16{8'h53}}, 1'b1, {16{8'hed}}, 1, "post reset 53");

        // Forward-only engine ignores mode.
        run_block(3, 128'h0, 1'b1, {16{8'h63}}, 3, "fwd only");

        // Random blocks against the table model.
        for (int i = 0; i < 16; i++) begin
            k = i % NI;
            d = {$urandom, $urandom, $urandom, $urandom};
            m = 1'($urandom);
            run_block(k, d, m, model(d, inv_of[k] ? m : 1'b0), int'($urandom_range(3)),
                      $sformatf("rand%0d u%0d", i, k));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
